paralelo_serial: RTL and testbench

Byte-to-bit serializer directly downstream of the two-level 4:1 byte multiplexer. It takes the multiplexed 8-bit lane (`Entrada`/`validEntrada`, produced at clk_4f) and shifts it out MSB-first on a single serial line at clk_32f. After reset it first transmits a fixed run of COM characters for receiver alignment, then sends data bytes. Any byte window without valid data carries an IDLE character.

---
 rtl/serdes_defs.sv | 7 +
 rtl/paralelo_serial.sv | 57 +++++
 tb/tb_paralelo_serial.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serdes_defs.sv
// serdes_defs: constants and state encoding shared by the serializer and deserializer.
package serdes_defs;
    localparam logic [7:0] COM_CHAR_DEF  = 8'hBC;
    localparam logic [7:0] IDLE_CHAR_DEF = 8'h7C;
    localparam int unsigned RATIO_32F_4F = 8;
    typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} state_t;
endpackage

// File: rtl/paralelo_serial.sv
// paralelo_serial: MSB-first byte serializer that sends SYNC_COUNT COM characters after reset, then data or IDLE.
// Optional idle-window counter output cuenta_idle enabled by PARALELO_SERIAL_IDLE_CNT_EN.
module paralelo_serial
    import serdes_defs::*;
#(
    parameter logic [7:0]  COM_CHAR   = COM_CHAR_DEF,
    parameter logic [7:0]  IDLE_CHAR  = IDLE_CHAR_DEF,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] Entrada,
    input  logic       validEntrada,
    output logic       Salida_serial,
    output logic       carga,
    output logic       activo
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
    ,
    output logic [15:0] cuenta_idle
`endif
);
    localparam logic [2:0] LAST = 3'(RATIO_32F_4F - 1);
    logic [7:0] shreg;
    logic [2:0] cnt;
    logic [3:0] com_cnt;
    state_t     state;
    logic       load;
    logic [7:0] next_byte;
    assign load          = cnt == LAST;
    assign next_byte     = state == ACTIVE ? (validEntrada ? Entrada : IDLE_CHAR) : COM_CHAR;
    assign Salida_serial = shreg[7];
    assign carga         = load && state == ACTIVE;
    assign activo        = state == ACTIVE;
    // cnt resets to LAST so the very first edge after reset is a load edge
    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) begin
            shreg   <= '0;
            cnt     <= LAST;
            com_cnt <= '0;
            state   <= SYNC;
        end else if (load) begin
            shreg <= next_byte;
            cnt   <= '0;
            if (state == SYNC) begin
                com_cnt <= com_cnt + 4'd1;
                if (com_cnt + 4'd1 == 4'(SYNC_COUNT)) state <= ACTIVE;
            end
        end else begin
            shreg <= {shreg[6:0], 1'b0};
            cnt   <= cnt + 3'd1;
        end
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
    always_ff @(posedge clk_32f or negedge reset)
        if (!reset) cuenta_idle <= '0;
        else if (carga && !validEntrada && cuenta_idle != 16'hFFFF) cuenta_idle <= cuenta_idle + 16'd1;
`endif
endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial: directed checks of the serializer with default SYNC_COUNT and SYNC_COUNT=1.
module tb_paralelo_serial;
    logic       clk = 1'b0;
    logic       r0n, r1n, v0, v1;
    logic [7:0] e0, e1;
    logic       s0, s1, c0, c1, a0, a1;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] com = 8'hBC;
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
    logic [15:0] i0, i1;
`endif

    always #5 clk = ~clk;

    paralelo_serial dut0 (
        .clk_32f(clk), .reset(r0n), .Entrada(e0), .validEntrada(v0),
        .Salida_serial(s0), .carga(c0), .activo(a0)
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        , .cuenta_idle(i0)
`endif
    );

    paralelo_serial #(.SYNC_COUNT(1)) dut1 (
        .clk_32f(clk), .reset(r1n), .Entrada(e1), .validEntrada(v1),
        .Salida_serial(s1), .carga(c1), .activo(a1)
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        , .cuenta_idle(i1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // drive one byte window starting in a cycle just before a load edge
    task automatic send(input bit w, input logic [7:0] d, input logic v, input logic [7:0] exp);
        if (w) begin e1 = d; v1 = v; end
        else begin e0 = d; v0 = v; end
        for (int i = 7; i >= 0; i--) begin
            tick();
            chk($sformatf("d%0d bit%0d of %0h", w, i, exp), w ? s1 : s0, exp[i]);
            chk($sformatf("d%0d carga bit%0d", w, i), w ? c1 : c0, i == 0);
        end
    endtask

    initial begin
        r0n = 1'b0; r1n = 1'b0;
        e0 = 8'h5A; v0 = 1'b0; e1 = 8'h55; v1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst ser", s0, 0);
        chk("rst carga", c0, 0);
        chk("rst activo", a0, 0);
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("rst idle", i0, 0);
`endif
        r0n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            chk($sformatf("sync bit e%0d", k), s0, com[7 - ((k - 1) % 8)]);
            chk($sformatf("sync activo e%0d", k), a0, k >= 25);
            chk($sformatf("sync carga e%0d", k), c0, k == 32);
        end
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("idle after sync", i0, 0);
`endif
        send(0, 8'hA5, 1, 8'hA5);
        send(0, 8'h33, 0, 8'h7C);
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("idle cnt 1", i0, 1);
`endif
        send(0, 8'h01, 1, 8'h01);
        send(0, 8'h80, 1, 8'h80);
        send(0, 8'hFF, 1, 8'hFF);
        send(0, 8'hBC, 1, 8'hBC);
        send(0, 8'h7C, 1, 8'h7C);
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("idle verbatim", i0, 1);
`endif
        send(0, 8'hC3, 0, 8'h7C);
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("idle cnt 2", i0, 2);
`endif
        e0 = 8'hA5; v0 = 1'b1;
        for (int i = 7; i >= 3; i--) begin
            tick();
            chk($sformatf("pre-rst bit%0d", i), s0, e0[i]);
        end
        r0n = 1'b0;
        #1;
        chk("async ser", s0, 0);
        chk("async carga", c0, 0);
        chk("async activo", a0, 0);
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("async idle", i0, 0);
`endif
        repeat (3) @(negedge clk);
        r0n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("resync bit e%0d", k), s0, com[8 - k]);
            chk($sformatf("resync activo e%0d", k), a0, 0);
            chk($sformatf("resync carga e%0d", k), c0, 0);
        end
        r1n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("s1 bit e%0d", k), s1, com[8 - k]);
            chk($sformatf("s1 activo e%0d", k), a1, 1);
            chk($sformatf("s1 carga e%0d", k), c1, k == 8);
        end
        send(1, 8'hC3, 1, 8'hC3);
        send(1, 8'h3C, 0, 8'h7C);
`ifdef PARALELO_SERIAL_IDLE_CNT_EN
        chk("s1 idle cnt", i1, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
